// File: rtl/ro_trng_pkg.sv
// Shared types and default sizing for the ring-oscillator TRNG slice.
// The sampler and the TRNG top agree on state encoding and word geometry through this package.
package ro_trng_pkg;

  localparam int unsigned NUM_RO_DEF    = 8;
  localparam int unsigned WORD_W_DEF    = 32;
  localparam int unsigned REP_LIMIT_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    SAMPLE = 3'd2,
    HOLD   = 3'd3,
    FAIL   = 3'd4
  } state_t;

endpackage

// File: rtl/ro_sync.sv
// Two-flop synchronizer bringing free-running oscillator outputs into the clk domain.
// Both stages are kept together and unoptimised so placement keeps them adjacent.
module ro_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic [W-1:0] meta;
  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic [W-1:0] sync;

  // NOTE: no reset on synchronizer data flops; they carry no state worth restoring
  // and a reset term would sit in the metastability path.
  // NOTE: sequential state always uses non-blocking assignment so both stages
  // sample the pre-edge values and the chain really is two flops deep.
  always_ff @(posedge clk) begin
    meta <= d;
    sync <= meta;
  end

  assign q = sync;

endmodule

// File: rtl/ro_sampler.sv
// Enables the ring oscillators, samples their XOR into a shift register under a
// repetition-count health test, and hands full words out on a valid/ready stream.
module ro_sampler
  import ro_trng_pkg::*;
#(
  parameter int unsigned NUM_RO        = NUM_RO_DEF,
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter int unsigned SAMPLE_DIV    = 4,
  parameter int unsigned WORD_W        = WORD_W_DEF,
  parameter int unsigned REP_LIMIT     = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_en,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic              health_fail
);

  localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES) + 1;
  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV) + 1;
  localparam int unsigned BIT_W  = $clog2(WORD_W) + 1;
  localparam int unsigned REP_W  = $clog2(REP_LIMIT) + 1;

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

  state_t              state, state_nxt;
  logic [WARM_W-1:0]   warm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [REP_W-1:0]    rep_cnt;
  logic                prev_bit;
  logic [WORD_W-1:0]   shreg;
  logic [NUM_RO-1:0]   ro_sync_q;
  logic                raw_bit;
  logic                strobe, rep_hit, shift_en, word_done, load_en, run_nxt;

  ro_sync #(.W(NUM_RO)) u_sync (
    .clk (clk),
    .d   (ro_out),
    .q   (ro_sync_q)
  );

  assign raw_bit   = ^ro_sync_q;
  assign strobe    = (state == SAMPLE) && (div_cnt == DIV_LAST);
  assign rep_hit   = (rep_cnt == REP_MAX);
  // A failing health count or a stop request wins over shifting and loading.
  assign shift_en  = strobe && start && !rep_hit;
  assign word_done = shift_en && (bit_cnt == BIT_LAST);
  assign load_en   = (state == HOLD) && start && !rep_hit && (!rnd_valid || rnd_ready);
  assign run_nxt   = (state_nxt == WARMUP) || (state_nxt == SAMPLE) || (state_nxt == HOLD);

  // NOTE: combinational next-state logic assigns a default first so no path
  // leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WARMUP;
      WARMUP: begin
        if (!start)                     state_nxt = IDLE;
        else if (warm_cnt == WARM_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (rep_hit)        state_nxt = FAIL;
        else if (!start)    state_nxt = IDLE;
        else if (word_done) state_nxt = HOLD;
      end
      HOLD: begin
        if (rep_hit)      state_nxt = FAIL;
        else if (!start)  state_nxt = IDLE;
        else if (load_en) state_nxt = SAMPLE;
      end
      FAIL:    state_nxt = FAIL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      prev_bit  <= 1'b0;
      shreg     <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      ro_en     <= '0;
    end else begin
      state <= state_nxt;
      ro_en <= {NUM_RO{run_nxt}};

      if ((state == WARMUP) && (state_nxt == WARMUP)) warm_cnt <= warm_cnt + 1'b1;
      else                                            warm_cnt <= '0;

      // div_cnt is frozen in HOLD so sampling resumes on a clean phase after a load.
      if (state == SAMPLE)                div_cnt <= strobe ? '0 : div_cnt + 1'b1;
      else if (state != HOLD || load_en)  div_cnt <= '0;

      if (shift_en) begin
        shreg    <= {shreg[WORD_W-2:0], raw_bit};
        bit_cnt  <= bit_cnt + 1'b1;
        prev_bit <= raw_bit;
        rep_cnt  <= (rep_cnt != '0 && raw_bit == prev_bit) ? rep_cnt + 1'b1 : REP_W'(1);
      end else begin
        if (load_en || !((state == SAMPLE) || (state == HOLD))) bit_cnt <= '0;
        if (state == WARMUP)                                     rep_cnt <= '0;
      end

      if (state_nxt == FAIL) begin
        rnd_valid <= 1'b0;
      end else if (load_en) begin
        rnd_valid <= 1'b1;
        rnd_data  <= shreg;
      end else if (rnd_valid && rnd_ready) begin
        rnd_valid <= 1'b0;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign health_fail = (state == FAIL);

endmodule
